spm_bank_mb: RTL and testbench
==============================

# spm_bank_mb

Multi-bank, two-port scratchpad memory bank with valid/ready request handshakes, per-lane write/read masks and tracked read responses. It replaces a single-bank SPM bank in the memory-buffer subsystem. Requests on ports A and B are routed to NUM_BANK address-interleaved banks, and same-bank conflicts are resolved by round-robin arbitration. Each read is returned with a valid strobe a fixed NB_PIPE+1 cycles after acceptance.

## Interface
- NUM_LANE, 128, lanes per bank row
- NUM_BANK, 2, number of banks; power of two, at least 2
- BANK_ADDR_WIDTH, 12, row address width inside one bank
- BANK_DEPTH, 4096, rows per bank; at most 2**BANK_ADDR_WIDTH
- DATA_WIDTH, 64, bits per lane
- NB_PIPE, 3, read output pipeline stages; at least 1
- RAM_TYPE, "URAM", storage style hint ("URAM" or "BRAM"); has no effect on behaviour
- ADDR_WIDTH (localparam) = BANK_ADDR_WIDTH + $clog2(NUM_BANK)
- clk  input  1  single clock; everything is sampled on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- For each port x in {a, b}:
  - i_x_valid  input  1  request valid
  - o_x_ready  output  1  request accepted this cycle when high together with i_x_valid
  - i_x_wr_en  input  1  1 = write, 0 = read
  - i_x_addr  input  ADDR_WIDTH  bank = addr[$clog2(NUM_BANK)-1:0]; row = upper bits
  - i_x_wr_data  input  DATA_WIDTH*NUM_LANE  write data; lane i = [i*DATA_WIDTH +: DATA_WIDTH]
  - i_x_lane_mask  input  NUM_LANE  per-lane enable for both writes and reads
  - o_x_rd_valid  output  1  read response strobe
  - o_x_rd_data  output  DATA_WIDTH*NUM_LANE  read response data
- o_conflict_cnt  output  16  saturating count of conflict cycles

## Operation
- Bank select: bank = low address bits; row = high address bits. Rows at or above BANK_DEPTH are undefined; the bench does not drive them.
- Conflict: asserted when i_a_valid, i_b_valid and equal bank fields are all true in the same cycle.
  - Without a conflict, both ready outputs are 1.
  - With a conflict, only the port holding priority sees ready = 1.
  - Ready is combinational from the valids, addresses and the prio register.
- prio register:
  - 0 = A has priority; resets to 0.
  - Toggles at the end of every conflict cycle, so the losing port wins next time.
  - Holds its value on non-conflict cycles.
- Accepted write: lanes with mask = 1 are written to the selected bank row; lanes with mask = 0 keep their contents. No response is produced.
- Accepted read:
  - Selected bank row is read.
  - Bank select, lane mask and valid travel down a per-port shift pipeline alongside the data.
  - Output lanes with mask = 0 return 0.
- Both ports may be accepted in the same cycle on different banks, one request per port per cycle, fully pipelined. Responses return in acceptance order and cannot be backpressured.
- When o_x_rd_valid = 0, o_x_rd_data = 0.
- o_conflict_cnt increments by 1 per conflict cycle and saturates at 16'hFFFF.
- Storage is not initialised by reset. Contents persist across reset.

## Timing
- Read latency: a request accepted at rising edge T (valid and ready high before T) drives o_x_rd_valid high for one cycle after edge T+NB_PIPE+1, i.e. L = NB_PIPE+1.
- Write latency: a write accepted at edge T is visible to a read accepted at edge T+1 or later on either port. The read sees the new data.
- Same-bank same-cycle accesses cannot occur because arbitration serialises them.
- Reset mid-operation:
  - rst_n low immediately clears all response valids, response data, prio and o_conflict_cnt.
  - In-flight reads are dropped and never produce rd_valid after reset.
  - Writes accepted before reset remain stored.
- Reset values: o_a_rd_valid = 0, o_b_rd_valid = 0, o_a_rd_data = 0, o_b_rd_data = 0, o_conflict_cnt = 0.
  - Ready outputs follow the combinational rule with prio = 0.

## Test plan
Bench parameters: NUM_LANE=4, NUM_BANK=2, DATA_WIDTH=16, NB_PIPE=3.
- Basic write/read: write addr 0x002 = {0x4444,0x3333,0x2222,0x1111}, mask 4'hF, on A; read 0x002 on B one cycle later -> o_b_rd_valid pulses exactly 4 cycles after acceptance with the same data.
- Partial write and masked read: write addr 0x004 = all 0xFFFF, mask 4'b0101, over prior all 0x0000; read with mask 4'hF -> {0x0000,0xFFFF,0x0000,0xFFFF}; read with mask 4'b0001 -> {0,0,0,0xFFFF}.
- Conflict alternation: A and B both read bank 0 (addr 0x000 and 0x002) for 4 consecutive cycles -> ready alternates A, B, A, B; o_conflict_cnt = 4; each port receives 2 responses in order.
- Parallel no-conflict: A streams bank-0 reads and B streams bank-1 reads for 8 cycles -> both ready held high, 8 back-to-back responses per port, o_conflict_cnt unchanged.
- Reset mid-flight: issue 3 reads, then pulse rst_n low 1 cycle after the last acceptance -> no rd_valid afterwards; a post-reset read returns data written before reset; o_conflict_cnt = 0.
- Saturation: force 65540 conflict cycles -> o_conflict_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/spm_bank_mb.sv
// spm_bank_mb: two-port, multi-bank scratchpad with valid/ready request handshakes.
// Requests on ports A and B are routed to NUM_BANK address-interleaved banks. Both
// ports may be accepted in the same cycle when they target different banks; a
// same-bank collision goes to whichever port holds round-robin priority.
// Reads return a fixed NB_PIPE+1 cycles after acceptance, in order, with no backpressure.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_x_valid / o_x_ready       request handshake (ready is combinational)
//   i_x_wr_en                   1 = write, 0 = read
//   i_x_addr                    {row, bank}; the bank select is the low bits
//   i_x_wr_data, i_x_lane_mask  write data and per-lane enable (writes and reads)
//   o_x_rd_valid, o_x_rd_data   read response; data is 0 when valid is low
//   o_conflict_cnt              saturating count of same-bank conflict cycles
module spm_bank_mb #(
   parameter int unsigned NUM_LANE        = 128,
   parameter int unsigned NUM_BANK        = 2,
   parameter int unsigned BANK_ADDR_WIDTH = 12,
   parameter int unsigned BANK_DEPTH      = 4096,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned NB_PIPE         = 3,
   parameter string       RAM_TYPE        = "URAM",
   localparam int unsigned ADDR_WIDTH     = BANK_ADDR_WIDTH + $clog2(NUM_BANK)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_a_valid,
   output logic                           o_a_ready,
   input  logic                           i_a_wr_en,
   input  logic [ADDR_WIDTH-1:0]          i_a_addr,
   input  logic [DATA_WIDTH*NUM_LANE-1:0] i_a_wr_data,
   input  logic [NUM_LANE-1:0]            i_a_lane_mask,
   output logic                           o_a_rd_valid,
   output logic [DATA_WIDTH*NUM_LANE-1:0] o_a_rd_data,
   input  logic                           i_b_valid,
   output logic                           o_b_ready,
   input  logic                           i_b_wr_en,
   input  logic [ADDR_WIDTH-1:0]          i_b_addr,
   input  logic [DATA_WIDTH*NUM_LANE-1:0] i_b_wr_data,
   input  logic [NUM_LANE-1:0]            i_b_lane_mask,
   output logic                           o_b_rd_valid,
   output logic [DATA_WIDTH*NUM_LANE-1:0] o_b_rd_data,
   output logic [15:0]                    o_conflict_cnt
);

   localparam int unsigned SEL_W = $clog2(NUM_BANK);
   localparam int unsigned ROW_W = DATA_WIDTH * NUM_LANE;
   localparam int unsigned NP    = 2;

   // Port-indexed views of the request inputs (index 0 = A, 1 = B).
   logic [NP-1:0]                      req_valid;
   logic [NP-1:0]                      req_wr;
   logic [NP-1:0][ADDR_WIDTH-1:0]      req_addr;
   logic [NP-1:0][ROW_W-1:0]           req_data;
   logic [NP-1:0][NUM_LANE-1:0]        req_mask;
   logic [NP-1:0][SEL_W-1:0]           req_bank;
   logic [NP-1:0][BANK_ADDR_WIDTH-1:0] req_row;

   assign req_valid = {i_b_valid, i_a_valid};
   assign req_wr    = {i_b_wr_en, i_a_wr_en};
   assign req_addr  = {i_b_addr, i_a_addr};
   assign req_data  = {i_b_wr_data, i_a_wr_data};
   assign req_mask  = {i_b_lane_mask, i_a_lane_mask};

   // Split each address into bank select (low bits) and row (high bits).
   always_comb begin
      req_bank = '0;
      req_row  = '0;
      for (int p = 0; p < NP; p++) begin
         req_bank[p] = req_addr[p][SEL_W-1:0];
         req_row[p]  = req_addr[p][ADDR_WIDTH-1:SEL_W];
      end
   end

   // Arbitration: on a same-bank collision only the priority holder is ready.
   logic          prio;
   logic          conflict_c;
   logic [NP-1:0] ready_c;
   logic [NP-1:0] acc_c;

   assign conflict_c = (&req_valid) && (req_bank[0] == req_bank[1]);
   assign ready_c    = {~conflict_c | prio, ~conflict_c | ~prio};
   assign acc_c      = req_valid & ready_c;
   assign o_a_ready  = ready_c[0];
   assign o_b_ready  = ready_c[1];

   // Priority flips after every conflict so the loser wins next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio           <= 1'b0;
         o_conflict_cnt <= '0;
      end else if (conflict_c) begin
         prio <= ~prio;
         if (o_conflict_cnt != 16'hFFFF) begin
            o_conflict_cnt <= o_conflict_cnt + 16'd1;
         end
      end
   end

   // Registered read data of every bank; valid one cycle after acceptance.
   logic [NUM_BANK-1:0][ROW_W-1:0] bank_rd;

   for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic                       wen;
      logic                       ren;
      logic [BANK_ADDR_WIDTH-1:0] wrow;
      logic [BANK_ADDR_WIDTH-1:0] rrow;
      logic [ROW_W-1:0]           wdata;
      logic [NUM_LANE-1:0]        wmask;

      // At most one port is accepted per bank, so a simple mux picks it.
      always_comb begin
         wen   = 1'b0;
         ren   = 1'b0;
         wrow  = '0;
         rrow  = '0;
         wdata = '0;
         wmask = '0;
         for (int p = 0; p < NP; p++) begin
            if (acc_c[p] && (req_bank[p] == SEL_W'(b))) begin
               if (req_wr[p]) begin
                  wen   = 1'b1;
                  wrow  = req_row[p];
                  wdata = req_data[p];
                  wmask = req_mask[p];
               end else begin
                  ren  = 1'b1;
                  rrow = req_row[p];
               end
            end
         end
      end

      // One narrow RAM per lane gives native per-lane write enables.
      for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
         logic [DATA_WIDTH-1:0] rd_q;

         if (RAM_TYPE == "BRAM") begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
            always_ff @(posedge clk) begin
               if (wen && wmask[l]) mem[wrow] <= wdata[l*DATA_WIDTH +: DATA_WIDTH];
               if (ren)             rd_q      <= mem[rrow];
            end
         end else begin : g_uram
            (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
            always_ff @(posedge clk) begin
               if (wen && wmask[l]) mem[wrow] <= wdata[l*DATA_WIDTH +: DATA_WIDTH];
               if (ren)             rd_q      <= mem[rrow];
            end
         end

         assign bank_rd[b][l*DATA_WIDTH +: DATA_WIDTH] = rd_q;
      end
   end

   // Per-port response pipeline: read-side tag, NB_PIPE stages, output register.
   logic [NP-1:0]                        s0_valid;
   logic [NP-1:0][SEL_W-1:0]             s0_bank;
   logic [NP-1:0][NUM_LANE-1:0]          s0_mask;
   logic [NB_PIPE-1:0][NP-1:0]           pipe_valid;
   logic [NB_PIPE-1:0][NP-1:0][NUM_LANE-1:0] pipe_mask;
   logic [NB_PIPE-1:0][NP-1:0][ROW_W-1:0]    pipe_data;
   logic [NP-1:0]                        rd_valid_q;
   logic [NP-1:0][ROW_W-1:0]             rd_data_q;
   logic [NP-1:0][ROW_W-1:0]             rd_data_c;

   // Unmasked lanes and idle cycles return zero.
   always_comb begin
      rd_data_c = '0;
      for (int p = 0; p < NP; p++) begin
         for (int l = 0; l < NUM_LANE; l++) begin
            if (pipe_valid[NB_PIPE-1][p] && pipe_mask[NB_PIPE-1][p][l]) begin
               rd_data_c[p][l*DATA_WIDTH +: DATA_WIDTH] =
                  pipe_data[NB_PIPE-1][p][l*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid   <= '0;
         s0_bank    <= '0;
         s0_mask    <= '0;
         pipe_valid <= '0;
         pipe_mask  <= '0;
         pipe_data  <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         s0_valid <= acc_c & ~req_wr;
         s0_bank  <= req_bank;
         s0_mask  <= req_mask;
         for (int j = NB_PIPE - 1; j > 0; j--) begin
            pipe_valid[j] <= pipe_valid[j-1];
            pipe_mask[j]  <= pipe_mask[j-1];
            pipe_data[j]  <= pipe_data[j-1];
         end
         for (int p = 0; p < NP; p++) begin
            pipe_valid[0][p] <= s0_valid[p];
            pipe_mask[0][p]  <= s0_mask[p];
            pipe_data[0][p]  <= bank_rd[s0_bank[p]];
         end
         rd_valid_q <= pipe_valid[NB_PIPE-1];
         rd_data_q  <= rd_data_c;
      end
   end

   assign o_a_rd_valid = rd_valid_q[0];
   assign o_b_rd_valid = rd_valid_q[1];
   assign o_a_rd_data  = rd_data_q[0];
   assign o_b_rd_data  = rd_data_q[1];

endmodule

// File: tb/tb_spm_bank_mb.sv
// tb_spm_bank_mb: self-checking bench for spm_bank_mb with a transaction-level model
// (flat row memory, arbitration rule, and per-port queues of expected responses).
module tb_spm_bank_mb;

   localparam int unsigned NL = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned NPIPE = 3;
   localparam int unsigned AW = 13;
   localparam int unsigned RW = NL * DW;

   typedef struct packed {
      logic          v;
      logic          w;
      logic [AW-1:0] addr;
      logic [RW-1:0] d;
      logic [NL-1:0] m;
   } req_t;

   typedef struct {
      int            due;
      logic [RW-1:0] d;
   } resp_t;

   logic          clk;
   logic          rst_n;
   logic          i_a_valid, i_a_wr_en, o_a_ready, o_a_rd_valid;
   logic [AW-1:0] i_a_addr;
   logic [RW-1:0] i_a_wr_data, o_a_rd_data;
   logic [NL-1:0] i_a_lane_mask;
   logic          i_b_valid, i_b_wr_en, o_b_ready, o_b_rd_valid;
   logic [AW-1:0] i_b_addr;
   logic [RW-1:0] i_b_wr_data, o_b_rd_data;
   logic [NL-1:0] i_b_lane_mask;
   logic [15:0]   o_conflict_cnt;

   spm_bank_mb #(
      .NUM_LANE(NL), .NUM_BANK(2), .BANK_ADDR_WIDTH(12), .BANK_DEPTH(4096),
      .DATA_WIDTH(DW), .NB_PIPE(NPIPE), .RAM_TYPE("URAM")
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_wr_en(i_a_wr_en),
      .i_a_addr(i_a_addr), .i_a_wr_data(i_a_wr_data), .i_a_lane_mask(i_a_lane_mask),
      .o_a_rd_valid(o_a_rd_valid), .o_a_rd_data(o_a_rd_data),
      .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_wr_en(i_b_wr_en),
      .i_b_addr(i_b_addr), .i_b_wr_data(i_b_wr_data), .i_b_lane_mask(i_b_lane_mask),
      .o_b_rd_valid(o_b_rd_valid), .o_b_rd_data(o_b_rd_data),
      .o_conflict_cnt(o_conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc;
   logic          mprio;
   logic [15:0]   mcnt;
   logic [RW-1:0] mm [16];
   resp_t         qa[$], qb[$];
   logic [RW-1:0] got_a[$], got_b[$];
   logic          last_ra, last_rb;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] lanes(input logic [NL-1:0] m);
      logic [RW-1:0] r;
      for (int l = 0; l < NL; l++) r[l*DW +: DW] = {DW{m[l]}};
      return r;
   endfunction

   function automatic req_t rd(input int a, input logic [NL-1:0] m);
      req_t r = '0;
      r.v = 1'b1; r.addr = AW'(a); r.m = m;
      return r;
   endfunction

   function automatic req_t wr(input int a, input logic [RW-1:0] d, input logic [NL-1:0] m);
      req_t r = '0;
      r.v = 1'b1; r.w = 1'b1; r.addr = AW'(a); r.d = d; r.m = m;
      return r;
   endfunction

   // Compare the response outputs and counter against the model at a negedge.
   task automatic check_outputs();
      logic          ev;
      logic [RW-1:0] ed;
      resp_t         e;
      ev = (qa.size() > 0) && (qa[0].due == cyc);
      ed = '0;
      if (ev) begin e = qa.pop_front(); ed = e.d; end
      check("a_rd_valid", RW'(o_a_rd_valid), RW'(ev));
      check("a_rd_data", o_a_rd_data, ed);
      if (o_a_rd_valid) got_a.push_back(o_a_rd_data);
      ev = (qb.size() > 0) && (qb[0].due == cyc);
      ed = '0;
      if (ev) begin e = qb.pop_front(); ed = e.d; end
      check("b_rd_valid", RW'(o_b_rd_valid), RW'(ev));
      check("b_rd_data", o_b_rd_data, ed);
      if (o_b_rd_valid) got_b.push_back(o_b_rd_data);
      check("conflict_cnt", RW'(o_conflict_cnt), RW'(mcnt));
   endtask

   task automatic drive(input req_t ra, input req_t rb);
      i_a_valid = ra.v; i_a_wr_en = ra.w; i_a_addr = ra.addr;
      i_a_wr_data = ra.d; i_a_lane_mask = ra.m;
      i_b_valid = rb.v; i_b_wr_en = rb.w; i_b_addr = rb.addr;
      i_b_wr_data = rb.d; i_b_lane_mask = rb.m;
   endtask

   // One clock cycle: check outputs, present requests, check ready, advance model.
   task automatic cycle(input req_t ra, input req_t rb);
      logic conf, ea, eb;
      @(negedge clk);
      check_outputs();
      drive(ra, rb);
      #1;
      conf = ra.v && rb.v && (ra.addr[0] == rb.addr[0]);
      ea   = !conf || !mprio;
      eb   = !conf || mprio;
      check("a_ready", RW'(o_a_ready), RW'(ea));
      check("b_ready", RW'(o_b_ready), RW'(eb));
      last_ra = o_a_ready;
      last_rb = o_b_ready;
      if (ra.v && ea && !ra.w) qa.push_back('{cyc + NPIPE + 2, mm[ra.addr[3:0]] & lanes(ra.m)});
      if (rb.v && eb && !rb.w) qb.push_back('{cyc + NPIPE + 2, mm[rb.addr[3:0]] & lanes(rb.m)});
      if (ra.v && ea && ra.w)
         mm[ra.addr[3:0]] = (mm[ra.addr[3:0]] & ~lanes(ra.m)) | (ra.d & lanes(ra.m));
      if (rb.v && eb && rb.w)
         mm[rb.addr[3:0]] = (mm[rb.addr[3:0]] & ~lanes(rb.m)) | (rb.d & lanes(rb.m));
      if (conf) begin
         mprio = !mprio;
         if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b0;
      drive('0, '0);
      #1;
      check("rst_a_valid", RW'(o_a_rd_valid), '0);
      check("rst_b_valid", RW'(o_b_rd_valid), '0);
      check("rst_a_data", o_a_rd_data, '0);
      check("rst_b_data", o_b_rd_data, '0);
      check("rst_cnt", RW'(o_conflict_cnt), '0);
      qa.delete(); qb.delete();
      mprio = 1'b0; mcnt = '0;
      @(posedge clk); cyc++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); cyc++;
   endtask

   localparam logic [RW-1:0] BASIC_D = 64'h4444_3333_2222_1111;
   localparam logic [RW-1:0] KEEP_D  = 64'hCAFE_BEEF_1234_5678;

   initial begin
      logic [3:0] pa, pb;
      logic       all_rdy;
      req_t       ra, rb;

      rst_n = 1'b0;
      drive('0, '0);
      cyc = 0; mprio = 1'b0; mcnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("init_a_valid", RW'(o_a_rd_valid), '0);
      check("init_b_valid", RW'(o_b_rd_valid), '0);
      check("init_a_data", o_a_rd_data, '0);
      check("init_b_data", o_b_rd_data, '0);
      check("init_cnt", RW'(o_conflict_cnt), '0);
      check("init_a_ready", RW'(o_a_ready), RW'(1'b1));
      check("init_b_ready", RW'(o_b_ready), RW'(1'b1));
      rst_n = 1'b1;
      @(posedge clk);

      // Fill rows 0..15 so every later read has defined contents.
      for (int i = 0; i < 8; i++)
         cycle(wr(2*i, {$urandom(), $urandom()}, 4'hF), wr(2*i+1, {$urandom(), $urandom()}, 4'hF));

      // Basic write on A, read on B one cycle later.
      cycle(wr(2, BASIC_D, 4'hF), '0);
      got_b.delete();
      cycle('0, rd(2, 4'hF));
      idle(6);
      check("basic_n_resp", RW'(got_b.size()), RW'(1));
      if (got_b.size() == 1) check("basic_data", got_b[0], BASIC_D);

      // Partial write, then full and single-lane reads.
      cycle(wr(4, '0, 4'hF), '0);
      cycle(wr(4, {RW{1'b1}}, 4'b0101), '0);
      got_b.delete();
      cycle('0, rd(4, 4'hF));
      cycle('0, rd(4, 4'b0001));
      idle(6);
      check("partial_n_resp", RW'(got_b.size()), RW'(2));
      if (got_b.size() == 2) begin
         check("partial_full", got_b[0], 64'h0000_FFFF_0000_FFFF);
         check("partial_lane0", got_b[1], 64'h0000_0000_0000_FFFF);
      end

      // Same-bank conflicts for 4 cycles: A, B, A, B.
      got_a.delete(); got_b.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(rd(0, 4'hF), rd(2, 4'hF));
         pa[i] = last_ra;
         pb[i] = last_rb;
      end
      idle(6);
      #1;
      check("conf_a_ready_seq", RW'(pa), RW'(4'b0101));
      check("conf_b_ready_seq", RW'(pb), RW'(4'b1010));
      check("conf_cnt4", RW'(o_conflict_cnt), RW'(16'd4));
      check("conf_a_n_resp", RW'(got_a.size()), RW'(2));
      check("conf_b_n_resp", RW'(got_b.size()), RW'(2));

      // Parallel streams on different banks.
      got_a.delete(); got_b.delete();
      all_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle(rd(2*i, 4'hF), rd(2*i+1, 4'hF));
         all_rdy &= last_ra & last_rb;
      end
      idle(6);
      #1;
      check("par_ready", RW'(all_rdy), RW'(1'b1));
      check("par_a_n_resp", RW'(got_a.size()), RW'(8));
      check("par_b_n_resp", RW'(got_b.size()), RW'(8));
      check("par_cnt", RW'(o_conflict_cnt), RW'(16'd4));

      // Reset with reads in flight; stored data survives.
      cycle(wr(6, KEEP_D, 4'hF), '0);
      got_a.delete(); got_b.delete();
      cycle(rd(6, 4'hF), '0);
      cycle(rd(8, 4'hF), '0);
      cycle(rd(10, 4'hF), '0);
      cycle('0, '0);
      do_reset();
      idle(8);
      check("rst_dropped", RW'(got_a.size()), RW'(0));
      cycle('0, rd(6, 4'hF));
      idle(6);
      check("rst_keep_n", RW'(got_b.size()), RW'(1));
      if (got_b.size() == 1) check("rst_keep_data", got_b[0], KEEP_D);

      // Randomized traffic over rows 0..15.
      for (int i = 0; i < 400; i++) begin
         ra = '0; rb = '0;
         ra.v = ($urandom_range(3) != 0); ra.w = $urandom_range(1) == 1;
         ra.addr = AW'($urandom_range(15)); ra.d = {$urandom(), $urandom()};
         ra.m = NL'($urandom_range(15));
         rb.v = ($urandom_range(3) != 0); rb.w = $urandom_range(1) == 1;
         rb.addr = AW'($urandom_range(15)); rb.d = {$urandom(), $urandom()};
         rb.m = NL'($urandom_range(15));
         cycle(ra, rb);
      end
      idle(6);

      // Counter saturation.
      for (int i = 0; i < 65540; i++) cycle(rd(0, 4'hF), rd(2, 4'hF));
      idle(6);
      #1;
      check("sat_cnt", RW'(o_conflict_cnt), RW'(16'hFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
